// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I subset (jal, jalr, OP-IMM, OP, sb, bne, lui, lbu).
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP until reset.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       PCUpdate_o,
    output logic       Branch_o,
    output logic       RegWrite_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] ResultSrc_o,
    output logic [2:0] ImmSrc_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JALR     = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [3:0] state_q, state_d;
    logic       mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_update_c;
    logic       branch_c, reg_write_c, retire_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, result_src_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore decode; only memory states look at mem_ready_i
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        reg_write_c  = 1'b0;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready_i) begin
                    ir_write_c  = 1'b1;
                    pc_update_c = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready_i) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c  = 2'b10;
                alu_op_c = 2'b10;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c  = 2'b10;
                src_b_c  = 2'b01;
                alu_op_c = 2'b10;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c  = 2'b10;
                alu_op_c = 2'b01;
                branch_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JALR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = S_JAL;
            end
            // PC takes the target held in ALUOut while OldPC+4 is computed for the link
            S_JAL: begin
                src_a_c     = 2'b01;
                src_b_c     = 2'b10;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                result_src_c = 2'b11;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_c = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        case (op_i)
            OP_STORE: ImmSrc_o = 3'b001;
            OP_BR:    ImmSrc_o = 3'b010;
            OP_JAL:   ImmSrc_o = 3'b011;
            OP_LUI:   ImmSrc_o = 3'b100;
            default:  ImmSrc_o = 3'b000;
        endcase
    end

    // Side-effecting strobes are held off for as long as reset is asserted
    assign mem_req_o   = mem_req_c   & rst_n;
    assign MemWrite_o  = mem_write_c & rst_n;
    assign IRWrite_o   = ir_write_c  & rst_n;
    assign PCUpdate_o  = pc_update_c & rst_n;
    assign RegWrite_o  = reg_write_c & rst_n;
    assign retire_o    = retire_c    & rst_n;
    assign AdrSrc_o    = adr_src_c;
    assign Branch_o    = branch_c;
    assign ALUSrcA_o   = src_a_c;
    assign ALUSrcB_o   = src_b_c;
    assign ALUOp_o     = alu_op_c;
    assign ResultSrc_o = result_src_c;
    assign illegal_o   = illegal_c;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction phase lists with random memory waits.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_control;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                           MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                           ALUWB = 4'd8, BRANCH = 4'd9, JALR = 4'd10, JAL = 4'd11,
                           LUI = 4'd12, TRAP = 4'd13;

    logic       clk, rst_n, mem_ready_i;
    logic [6:0] op_i;
    logic       mem_req_o, AdrSrc_o, MemWrite_o, IRWrite_o, PCUpdate_o, Branch_o, RegWrite_o;
    logic [1:0] ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o;
    logic [2:0] ImmSrc_o;
    logic       retire_o, illegal_o;
    logic [3:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] path_q[$];
    logic [6:0] ops[9];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .AdrSrc_o(AdrSrc_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .PCUpdate_o(PCUpdate_o), .Branch_o(Branch_o),
        .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
        .ALUOp_o(ALUOp_o), .ResultSrc_o(ResultSrc_o), .ImmSrc_o(ImmSrc_o),
        .retire_o(retire_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] dut_vec();
        return {mem_req_o, AdrSrc_o, MemWrite_o, IRWrite_o, PCUpdate_o, Branch_o, RegWrite_o,
                ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, ImmSrc_o, retire_o, illegal_o, state_o};
    endfunction

    function automatic logic known(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    // Control table straight from the per-state description
    function automatic logic [23:0] exp_vec(input logic [3:0] s, input logic rdy, input logic [6:0] op);
        logic mreq, adr, mw, irw, pcu, br, rw, ret, ill;
        logic [1:0] sa, sb, aop, res;
        {mreq, adr, mw, irw, pcu, br, rw, ret, ill} = '0;
        {sa, sb, aop, res} = '0;
        case (s)
            FETCH:    begin mreq = 1; sb = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
            DECODE: begin
                sa = 2'b01; sb = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                ret = !known(op);
`endif
            end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  begin mreq = 1; adr = 1; end
            MEMWB:    begin res = 2'b01; rw = 1; ret = 1; end
            MEMWRITE: begin mreq = 1; adr = 1; mw = 1; ret = rdy; end
            EXECR:    begin sa = 2'b10; aop = 2'b10; end
            EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            ALUWB:    begin rw = 1; ret = 1; end
            BRANCH:   begin sa = 2'b10; aop = 2'b01; br = 1; ret = 1; end
            JALR:     begin sa = 2'b10; sb = 2'b01; end
            JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            LUI:      begin res = 2'b11; rw = 1; ret = 1; end
            TRAP:     begin ill = 1; end
            default:  ;
        endcase
        return {mreq, adr, mw, irw, pcu, br, rw, sa, sb, aop, res, imm_of(op), ret, ill, s};
    endfunction

    // Phase sequence of one instruction, by instruction class
    function automatic void build_path(input logic [6:0] op);
        path_q = '{FETCH, DECODE};
        case (op)
            7'b0000011: begin path_q.push_back(MEMADR); path_q.push_back(MEMREAD); path_q.push_back(MEMWB); end
            7'b0100011: begin path_q.push_back(MEMADR); path_q.push_back(MEMWRITE); end
            7'b0110011: begin path_q.push_back(EXECR); path_q.push_back(ALUWB); end
            7'b0010011: begin path_q.push_back(EXECI); path_q.push_back(ALUWB); end
            7'b1100011: path_q.push_back(BRANCH);
            7'b1101111: begin path_q.push_back(JAL); path_q.push_back(ALUWB); end
            7'b1100111: begin path_q.push_back(JALR); path_q.push_back(JAL); path_q.push_back(ALUWB); end
            7'b0110111: path_q.push_back(LUI);
            default: ;
        endcase
    endfunction

    // Zero-wait cycle counts as published for each instruction
    function automatic int base_cycles(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011: return 4;
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b1100011: return 3;
            7'b1101111: return 4;
            7'b1100111: return 5;
            7'b0110111: return 3;
            default:    return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; fw/mw are wait cycles before ready in FETCH and MEMREAD/MEMWRITE
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        int cyc = 0;
        int rets = 0;
        int waits;
        build_path(op);
        foreach (path_q[i]) begin
            logic [3:0] s = path_q[i];
            if (s == FETCH || s == MEMREAD || s == MEMWRITE) begin
                waits = (s == FETCH) ? fw : mw;
                for (int w = 0; w <= waits; w++) begin
                    @(negedge clk);
                    op_i = op;
                    mem_ready_i = (w == waits);
                    #1;
                    chk($sformatf("op%b_%0d_w%0d", op, s, w), 32'(dut_vec()), 32'(exp_vec(s, mem_ready_i, op)));
                    rets += int'(retire_o);
                    cyc++;
                end
            end else begin
                @(negedge clk);
                mem_ready_i = 1'($urandom_range(0, 1));
                #1;
                chk($sformatf("op%b_%0d", op, s), 32'(dut_vec()), 32'(exp_vec(s, mem_ready_i, op)));
                rets += int'(retire_o);
                cyc++;
            end
        end
        chk($sformatf("cycles_op%b", op), 32'(cyc), 32'(base_cycles(op) + fw + (known(op) && (op == 7'b0000011 || op == 7'b0100011) ? mw : 0)));
        chk($sformatf("retires_op%b", op), 32'(rets), 32'd1);
    endtask

    initial begin
        int n_ops;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
        rst_n = 1'b0; mem_ready_i = 1'b1; op_i = 7'b0110011;
        #1;
        chk("reset_state", 32'(state_o), 32'(FETCH));
        chk("reset_strobes", 32'({mem_req_o, IRWrite_o, PCUpdate_o, MemWrite_o, RegWrite_o, retire_o}), 32'd0);
        @(negedge clk); @(negedge clk);
        mem_ready_i = 1'b0;
        rst_n = 1'b1;

        // Directed cases from the test plan
        for (int k = 0; k < 3; k++) run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 3, 2);
        run_instr(7'b1100111, 0, 0);
        run_instr(7'b1100011, 1, 0);
        run_instr(7'b0100011, 0, 3);
        run_instr(7'b0110111, 0, 0);
        run_instr(7'b1101111, 2, 0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(7'b1111111, 0, 0);
        n_ops = 9;
`else
        n_ops = 8;
`endif

        // Random instruction mix with random memory latency
        for (int k = 0; k < 60; k++)
            run_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset while a store waits on memory
        build_path(7'b0100011);
        @(negedge clk); op_i = 7'b0100011; mem_ready_i = 1'b1;
        @(negedge clk); mem_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_memwrite", 32'(state_o), 32'(MEMWRITE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(state_o), 32'(FETCH));
        chk("abort_strobes", 32'({mem_req_o, MemWrite_o}), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ready_i = 1'b1;
            #1;
            chk("held_reset", 32'({state_o, mem_req_o, MemWrite_o, IRWrite_o, PCUpdate_o, RegWrite_o, retire_o}), 32'({FETCH, 6'b0}));
        end
        @(negedge clk);
        mem_ready_i = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release_req", 32'({state_o, mem_req_o}), 32'({FETCH, 1'b1}));
        run_instr(7'b0010011, 1, 0);

`ifdef ILLEGAL_TRAP_EN
        // Unknown opcode parks in TRAP until reset
        @(negedge clk); op_i = 7'b1111111; mem_ready_i = 1'b1; #1;
        chk("trap_fetch", 32'(dut_vec()), 32'(exp_vec(FETCH, 1'b1, op_i)));
        @(negedge clk); #1;
        chk("trap_decode", 32'(dut_vec()), 32'(exp_vec(DECODE, 1'b1, op_i)));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("trap_hold", 32'(dut_vec()), 32'(exp_vec(TRAP, mem_ready_i, op_i)));
        end
        rst_n = 1'b0;
        #1;
        chk("trap_reset", 32'({state_o, illegal_o}), 32'({FETCH, 1'b0}));
        @(negedge clk);
        mem_ready_i = 1'b0;
        rst_n = 1'b1;
        run_instr(7'b0110111, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
